// File: rtl/cbus_sram_responder_pkg.sv
// Shared CBus types plus the responder state encoding.
package cbus_sram_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] mlen_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2,
    DONE = 2'd3
  } resp_state_t;

endpackage

// File: rtl/cbus_sram_responder_if.sv
// CBus request/response bundle between the arbiter and a memory endpoint.
// Handshake: a request is held with valid=1 for the whole transfer; every cycle
// the responder drives ready=1 is one beat, last marks the final beat, and
// dropping valid before last aborts the remaining beats.
interface cbus_sram_responder_if;
  import cbus_sram_responder_pkg::*;

  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport master (output oreq, input oresp);
  modport slave  (input oreq, output oresp);
endinterface

// File: rtl/cbus_sram_responder_sram_byte_we.sv
// Word-wide array with per-byte write enables and an asynchronous read port;
// kept behind a minimal port list so a vendor macro can drop in later.
module sram_byte_we #(
  parameter int unsigned DEPTH_WORDS = 65536,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [7:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cbus_sram_responder.sv
// CBus memory endpoint: single/INCR/FIXED bursts with byte strobes, a fixed
// initial latency, and harmless completion of out-of-range accesses.
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 65536,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cbus_sram_responder_if.slave bus,
  output resp_state_t          state_dbg
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd8;

  resp_state_t   state, state_nxt;
  logic [3:0]    lat_cnt, lat_nxt;
  logic [8:0]    beats_left, beats_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          is_wr, is_wr_nxt;
  logic [1:0]    burst_r, burst_nxt;
  logic          oor, oor_nxt;

  logic [63:0]   off;
  logic [63:0]   rdata;
  logic [7:0]    we;
  cbus_resp_t    resp;
  logic          unused_bits;

  assign off         = bus.oreq.addr - BASE_ADDR;
  assign unused_bits = ^{off[63:AW+3], off[2:0], bus.oreq.size};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      beats_left <= '0;
      idx        <= '0;
      is_wr      <= 1'b0;
      burst_r    <= '0;
      oor        <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_nxt;
      beats_left <= beats_nxt;
      idx        <= idx_nxt;
      is_wr      <= is_wr_nxt;
      burst_r    <= burst_nxt;
      oor        <= oor_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    beats_nxt = beats_left;
    idx_nxt   = idx;
    is_wr_nxt = is_wr;
    burst_nxt = burst_r;
    oor_nxt   = oor;
    case (state)
      IDLE: begin
        if (bus.oreq.valid) begin
          is_wr_nxt = bus.oreq.is_write;
          idx_nxt   = off[AW+2:3];
          beats_nxt = {1'b0, bus.oreq.len} + 9'd1;
          burst_nxt = bus.oreq.burst;
          oor_nxt   = (bus.oreq.addr < BASE_ADDR) || (bus.oreq.addr >= END_ADDR);
          if (LATENCY == 0) begin
            state_nxt = BEAT;
          end else begin
            state_nxt = WAIT;
            lat_nxt   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        // The entry cycle counts as the first idle cycle, so leave on the 1->0 step.
        if (!bus.oreq.valid) begin
          state_nxt = IDLE;
          lat_nxt   = '0;
        end else begin
          lat_nxt = lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state_nxt = BEAT;
        end
      end
      BEAT: begin
        if (!bus.oreq.valid) begin
          state_nxt = IDLE;
          beats_nxt = '0;
        end else if (beats_left == 9'd1) begin
          state_nxt = DONE;
          beats_nxt = '0;
        end else begin
          beats_nxt = beats_left - 9'd1;
          if (burst_r == AXI_BURST_INCR) idx_nxt = idx + AW'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gating on valid keeps an aborted beat from landing in the array.
  assign we = (state == BEAT && is_wr && !oor && bus.oreq.valid) ? bus.oreq.strobe : 8'h00;

  sram_byte_we #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .we    (we),
    .addr  (idx),
    .wdata (bus.oreq.data),
    .rdata (rdata)
  );

  always_comb begin
    resp       = '0;
    resp.ready = (state == BEAT);
    resp.last  = (state == BEAT) && (beats_left == 9'd1);
    resp.data  = (state == BEAT && !is_wr && !oor) ? rdata : 64'h0;
  end

  assign bus.oresp = resp;
  assign state_dbg = state;

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Directed bench for cbus_sram_responder: a 64-word/latency-2 instance and a
// 16-word/latency-0 instance for wrap and zero-latency behaviour.
module tb_cbus_sram_responder;
  import cbus_sram_responder_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cbus_sram_responder_if bus_a ();
  cbus_sram_responder_if bus_b ();
  resp_state_t st_a, st_b;

  cbus_sram_responder #(.DEPTH_WORDS(64), .BASE_ADDR(BASE), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .state_dbg(st_a));

  cbus_sram_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BASE), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .state_dbg(st_b));

  int vecs = 0;
  int errs = 0;
  logic [63:0] mem_a [64];
  logic [63:0] mem_b [16];
  logic [63:0] wdat_q [$];
  logic [63:0] rd_q [$];

  task automatic drive(input bit sel, input cbus_req_t r);
    if (sel) bus_b.oreq = r; else bus_a.oreq = r;
  endtask

  function automatic cbus_resp_t resp(input bit sel);
    return sel ? bus_b.oresp : bus_a.oresp;
  endfunction

  function automatic resp_state_t st(input bit sel);
    return sel ? st_b : st_a;
  endfunction

  function automatic logic [63:0] mget(input bit sel, input int idx);
    return sel ? mem_b[idx % 16] : mem_a[idx];
  endfunction

  task automatic mset(input bit sel, input int idx, input logic [7:0] strb, input logic [63:0] d);
    logic [63:0] w;
    w = mget(sel, idx);
    for (int b = 0; b < 8; b++) if (strb[b]) w[b*8 +: 8] = d[b*8 +: 8];
    if (sel) mem_b[idx] = w; else mem_a[idx] = w;
  endtask

  // Runs one request; beat index `stop` drops valid instead of transferring.
  task automatic run_burst(input bit sel, input bit wr, input logic [63:0] addr, input int len,
                           input logic [1:0] burst, input logic [7:0] strb, input int stop,
                           input bit hold, input string name);
    cbus_req_t  r;
    cbus_resp_t o;
    int depth, exp_lat, cyc, idx;
    logic [63:0] off, d, exp_d;
    bit oor;
    depth   = sel ? 16 : 64;
    exp_lat = sel ? 1 : 3;
    off     = addr - BASE;
    oor     = (addr < BASE) || (addr >= BASE + 64'(depth) * 64'd8);
    idx     = int'((off >> 3) & 64'(depth - 1));
    r = '0;
    r.valid = 1'b1; r.is_write = wr; r.size = MSIZE8; r.addr = addr;
    r.strobe = strb; r.len = 8'(len); r.burst = burst;
    drive(sel, r);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!resp(sel).ready && cyc < 40);
    vecs++;
    if (cyc !== exp_lat) begin
      errs++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
    end
    if (!resp(sel).ready) begin
      r.valid = 1'b0; drive(sel, r); @(posedge clk); #1;
      return;
    end
    for (int i = 0; i <= len; i++) begin
      if (i == stop) begin
        r.valid = 1'b0; drive(sel, r);
        @(posedge clk); #1;
        vecs++;
        if (st(sel) !== IDLE || resp(sel).ready !== 1'b0) begin
          errs++;
          $display("FAIL %s abort: state=%0d ready=%b, expected state=0 ready=0",
                   name, st(sel), resp(sel).ready);
        end
        return;
      end
      o = resp(sel);
      exp_d = (wr || oor) ? 64'h0 : mget(sel, idx);
      vecs++;
      if (o.ready !== 1'b1 || o.last !== (i == len) || o.data !== exp_d) begin
        errs++;
        $display("FAIL %s beat %0d: ready=%b last=%b data=%h, expected ready=1 last=%b data=%h",
                 name, i, o.ready, o.last, o.data, (i == len), exp_d);
      end
      if (!wr) rd_q.push_back(o.data);
      if (wr) begin
        d = (wdat_q.size() > 0) ? wdat_q.pop_front() : 64'h0;
        r.data = d;
        drive(sel, r);
        if (!oor) mset(sel, idx, strb, d);
      end
      @(posedge clk); #1;
      if (burst == AXI_BURST_INCR) idx = (idx + 1) % depth;
    end
    vecs++;
    if (resp(sel).ready !== 1'b0 || st(sel) !== DONE) begin
      errs++;
      $display("FAIL %s turnaround: ready=%b state=%0d, expected ready=0 state=3",
               name, resp(sel).ready, st(sel));
    end
    if (!hold) begin
      r.valid = 1'b0; drive(sel, r);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_a.oreq = '0;
    bus_b.oreq = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      vecs++;
      if (resp(s[0]).ready !== 1'b0 || resp(s[0]).last !== 1'b0 ||
          resp(s[0]).data !== 64'h0 || st(s[0]) !== IDLE) begin
        errs++;
        $display("FAIL reset_%0d: ready=%b last=%b data=%h state=%0d, expected all 0",
                 s, resp(s[0]).ready, resp(s[0]).last, resp(s[0]).data, st(s[0]));
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) wdat_q.push_back(64'hA5A5_0000_0000_0000 | 64'(i));
    run_burst(0, 1, BASE, 63, AXI_BURST_INCR, 8'hFF, -1, 0, "fill_a");
    for (int i = 0; i < 16; i++) wdat_q.push_back(64'hB0B0_0000_0000_0000 | 64'(i));
    run_burst(1, 1, BASE, 15, AXI_BURST_INCR, 8'hFF, -1, 0, "fill_b");
    wdat_q.push_back(64'h0123_4567_89AB_CDEF);
    run_burst(0, 1, BASE, 0, AXI_BURST_FIXED, 8'hFF, -1, 0, "preload");
  endtask

  task automatic test_single_read();
    rd_q.delete();
    run_burst(0, 0, BASE, 0, AXI_BURST_INCR, 8'h00, -1, 0, "single_read");
    vecs++;
    if (rd_q.size() != 1 || rd_q[0] !== 64'h0123_4567_89AB_CDEF) begin
      errs++;
      $display("FAIL single_read data: got %0d beats first=%h, expected 1 beat 0123456789abcdef",
               rd_q.size(), rd_q.size() ? rd_q[0] : 64'h0);
    end
  endtask

  task automatic test_strobe_write();
    wdat_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    run_burst(0, 1, BASE + 64'h10, 0, AXI_BURST_INCR, 8'h0F, -1, 0, "strobe_wr");
    rd_q.delete();
    run_burst(0, 0, BASE + 64'h10, 0, AXI_BURST_INCR, 8'h00, -1, 0, "strobe_rd");
    vecs++;
    if (rd_q.size() != 1 || rd_q[0] !== 64'hA5A5_0000_FFFF_FFFF) begin
      errs++;
      $display("FAIL strobe_word: got %h, expected a5a50000ffffffff",
               rd_q.size() ? rd_q[0] : 64'h0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    rd_q.delete();
    run_burst(0, 0, BASE + 64'h40, 15, AXI_BURST_INCR, 8'h00, -1, 1, "incr16");
    ok = (rd_q.size() == 16);
    for (int i = 0; i < 16 && ok; i++) if (rd_q[i] !== (64'hA5A5_0000_0000_0000 | 64'(8 + i))) ok = 0;
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL incr16 order: got %0d beats, expected words 8..23 in order", rd_q.size());
    end
    @(posedge clk); #1;
    vecs++;
    if (st_a !== IDLE || bus_a.oresp.ready !== 1'b0) begin
      errs++;
      $display("FAIL b2b_dead: state=%0d ready=%b, expected state=0 ready=0", st_a, bus_a.oresp.ready);
    end
    @(posedge clk); #1;
    vecs++;
    if (st_a !== WAIT) begin
      errs++;
      $display("FAIL b2b_accept: state=%0d, expected 1", st_a);
    end
    bus_a.oreq.valid = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (st_a !== IDLE || bus_a.oresp.ready !== 1'b0) begin
      errs++;
      $display("FAIL wait_abort: state=%0d ready=%b, expected state=0 ready=0", st_a, bus_a.oresp.ready);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) wdat_q.push_back(64'hC0DE_0000_0000_0000 | 64'(i));
    run_burst(1, 1, BASE + 64'd112, 3, AXI_BURST_INCR, 8'hFF, -1, 0, "wrap_wr");
    rd_q.delete();
    run_burst(1, 0, BASE, 15, AXI_BURST_INCR, 8'h00, -1, 0, "wrap_rd");
    vecs++;
    if (rd_q.size() != 16 || rd_q[14] !== 64'hC0DE_0000_0000_0000 || rd_q[15] !== 64'hC0DE_0000_0000_0001 ||
        rd_q[0] !== 64'hC0DE_0000_0000_0002 || rd_q[1] !== 64'hC0DE_0000_0000_0003 ||
        rd_q[2] !== 64'hB0B0_0000_0000_0002 || rd_q[13] !== 64'hB0B0_0000_0000_000D) begin
      errs++;
      $display("FAIL wrap_words: w14=%h w15=%h w0=%h w1=%h, expected c0de..0 c0de..1 c0de..2 c0de..3",
               rd_q[14], rd_q[15], rd_q[0], rd_q[1]);
    end
  endtask

  task automatic test_out_of_range();
    bit ok;
    rd_q.delete();
    run_burst(0, 0, 64'h7FFF_FFF8, 3, AXI_BURST_INCR, 8'h00, -1, 0, "oor_rd");
    ok = (rd_q.size() == 4);
    foreach (rd_q[i]) if (rd_q[i] !== 64'h0) ok = 0;
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL oor_rd_zero: got %0d beats, expected 4 beats of 0", rd_q.size());
    end
    wdat_q.push_back(64'hDEAD_BEEF_DEAD_BEEF);
    run_burst(0, 1, BASE + 64'd512, 0, AXI_BURST_INCR, 8'hFF, -1, 0, "oor_wr");
    rd_q.delete();
    run_burst(0, 0, BASE, 63, AXI_BURST_INCR, 8'h00, -1, 0, "oor_sweep");
    vecs++;
    if (rd_q.size() != 64 || rd_q[0] !== 64'h0123_4567_89AB_CDEF || rd_q[63] !== 64'hA5A5_0000_0000_003F) begin
      errs++;
      $display("FAIL oor_untouched: w0=%h w63=%h, expected 0123456789abcdef a5a500000000003f",
               rd_q[0], rd_q[63]);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) wdat_q.push_back(64'hAB00_0000_0000_0000 | 64'(i));
    run_burst(0, 1, BASE, 7, AXI_BURST_INCR, 8'hFF, 2, 0, "abort_wr");
    wdat_q.delete();
    rd_q.delete();
    run_burst(0, 0, BASE, 3, AXI_BURST_INCR, 8'h00, -1, 0, "abort_rd");
    vecs++;
    if (rd_q.size() != 4 || rd_q[0] !== 64'hAB00_0000_0000_0000 || rd_q[1] !== 64'hAB00_0000_0000_0001 ||
        rd_q[2] !== 64'hA5A5_0000_FFFF_FFFF || rd_q[3] !== 64'hA5A5_0000_0000_0003) begin
      errs++;
      $display("FAIL abort_words: w0=%h w1=%h w2=%h w3=%h, expected ab..00 ab..01 a5a50000ffffffff a5a5..03",
               rd_q[0], rd_q[1], rd_q[2], rd_q[3]);
    end
  endtask

  task automatic test_reset_mid_wait();
    cbus_req_t r;
    bit seen;
    r = '0;
    r.valid = 1'b1; r.size = MSIZE8; r.addr = BASE; r.len = 8'd3; r.burst = AXI_BURST_INCR;
    drive(0, r);
    @(posedge clk); #1;
    vecs++;
    if (st_a !== WAIT) begin
      errs++;
      $display("FAIL rst_pre: state=%0d, expected 1", st_a);
    end
    reset = 1'b0;
    bus_a.oreq.valid = 1'b0;
    #1;
    vecs++;
    if (bus_a.oresp.ready !== 1'b0 || st_a !== IDLE) begin
      errs++;
      $display("FAIL rst_async: ready=%b state=%0d, expected ready=0 state=0", bus_a.oresp.ready, st_a);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus_a.oresp.ready !== 1'b0) seen = 1;
    end
    vecs++;
    if (seen || st_a !== IDLE) begin
      errs++;
      $display("FAIL rst_no_beat: beat_seen=%b state=%0d, expected 0 and 0", seen, st_a);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_single_read();
    test_strobe_write();
    test_back_to_back();
    test_wrap();
    test_out_of_range();
    test_abort();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cbus_sram_responder.md
# cbus_sram_responder

Synthesizable CBus responder that terminates the cache-line bus on the far side of `CBusArbiter`. It replaces the simulation-only RAM helper as the memory endpoint. It accepts single and INCR-burst reads and writes from the arbiter's `oreq`, applies byte strobes, and returns data beat-by-beat on `oresp` with a configurable initial latency. Out-of-range accesses complete the handshake harmlessly, so the initiator never hangs.

## Interface
- `DEPTH_WORDS`, default 65536: number of 64-bit words stored; must be a power of two.
- `BASE_ADDR`, default 64'h8000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*8`.
- `LATENCY`, default 2: idle cycles between request acceptance and the first data beat, range 0..15.
- `clk`  in  1: the single clock; everything is on the rising edge.
- `reset`  in  1: asynchronous, active-low (0 = in reset).
- `oreq`  in  cbus_req_t: the arbiter's request (valid, is_write, size, addr, strobe, data, len, burst).
- `oresp`  out  cbus_resp_t: the response (ready, last, data).

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting down the initial latency.
  - BEAT: transferring data.
  - DONE: one-cycle turnaround.
- IDLE→WAIT when `oreq.valid`. On that edge, latch `is_write`, word index = (addr−BASE_ADDR)>>3, beat count = len+1, `burst`, and an out-of-range flag (addr < BASE_ADDR or addr ≥ BASE_ADDR+DEPTH_WORDS*8).
- WAIT:
  - The latency counter loads `LATENCY` on entry and decrements each cycle.
  - At 0 the block goes to BEAT.
  - With `LATENCY`=0, WAIT is skipped and IDLE goes straight to BEAT.
- BEAT:
  - `oresp.ready`=1 every cycle, one beat per cycle.
  - `oresp.last`=1 on the final beat.
  - After the final beat the block goes to DONE.
- DONE: `ready`=0 for one cycle, then IDLE. This ensures a request held valid on the cycle after `last` is not re-accepted.
- Read beats: `oresp.data` = mem[index], or 0 when out of range.
- Write beats:
  - For each byte b with `oreq.strobe[b]`=1, mem[index].byte[b] ← `oreq.data`.byte[b] on the edge.
  - The write is ignored when out of range.
  - Read `data` is 0 during writes.
- Index advance per beat:
  - INCR: +1, wrapping modulo `DEPTH_WORDS`.
  - FIXED: unchanged.
  - The out-of-range flag is evaluated once per request, not per beat.
- Narrow sizes (`size` < MSIZE8) are handled purely through `strobe` and the word index. The responder does not shift data; the initiator presents lane-aligned data.
- Abort: if `oreq.valid` falls in WAIT or BEAT, the block goes to IDLE next cycle with no further writes. Beats already written stay written.
- The memory array is not cleared by reset; contents are undefined until written.

## Timing
- Reset values: `oresp.ready`=0, `oresp.last`=0, `oresp.data`=0, state=IDLE, counters=0.
- First-beat latency: request sampled in IDLE at cycle t gives first `ready` at t+1+`LATENCY`. A burst of N beats occupies cycles t+1+L .. t+L+N.
- Back-to-back throughput: the next request is accepted at the earliest one cycle after DONE, i.e. 2 dead cycles after `last`.
- `ready`, `last` and `data` are combinational from registered state plus the array read. No output depends combinationally on `oreq` except the write strobe path into the array.
- Reset asserted mid-burst: immediate return to IDLE with outputs at reset values. Partially written words keep any beats that completed before reset.

## Structure
- The common package already holds cbus_req_t, cbus_resp_t, msize_t, mlen_t and the AXI_BURST_* constants; this block uses those.
- Add to common: the `resp_state_t` enum (IDLE/WAIT/BEAT/DONE).
- One sub-module: `sram_byte_we`, a `DEPTH_WORDS`×64 array with an 8-bit byte-write-enable and an asynchronous read port. It is replaceable by a vendor macro later.

## Test plan
- Single read:
  - Stimulus: preload word 0 with 64'h0123_4567_89AB_CDEF; read addr 8000_0000, len 0, `LATENCY`=2.
  - Required: `ready`=`last`=1 exactly 3 cycles after acceptance, data matches.
- Strobed write then read:
  - Stimulus: write 64'hFFFF_FFFF_FFFF_FFFF with strobe 8'h0F to 8000_0010; then read 8000_0010.
  - Required: upper four bytes unchanged, lower four bytes = FF.
- 16-beat INCR read:
  - Stimulus: addr 8000_0040, len 15.
  - Required: 16 consecutive `ready` cycles, `last` only on the 16th, words 8..23 in order; the next request is accepted no earlier than 2 cycles after `last`.
- Wrap:
  - Stimulus: `DEPTH_WORDS`=16, 4-beat INCR write starting at word 14.
  - Required: words 14, 15, 0, 1 written.
- Out of range:
  - Stimulus: read at 7FFF_FFF8, len 3; then a write at BASE+`DEPTH_WORDS`*8.
  - Required: 4 beats of data 0 with proper `last`; the write completes and no array word changes.
- Abort and reset:
  - Stimulus: drop `valid` after beat 2 of an 8-beat write.
  - Required: only words 0–1 modified, IDLE next cycle.
  - Stimulus: assert `reset` low mid-WAIT.
  - Required: `ready`=0 immediately, no beat is issued.
